// File: rtl/seven_seg_capture_if.sv
// Bundle of the scanned display inputs and the recovered digit/status outputs
// of the seven-segment capture monitor.
interface seven_seg_capture_if;
  logic [3:0] anode_in;
  logic [6:0] seg_in;
  logic [3:0] min_1;
  logic [3:0] min_0;
  logic [3:0] sec_1;
  logic [3:0] sec_0;
  logic       frame_valid;
  logic       digit_err;

  // Display-side driver (or bench) owns the scan lines and observes the digits.
  modport master (
    output anode_in, seg_in,
    input  min_1, min_0, sec_1, sec_0, frame_valid, digit_err
  );

  // Capture block observes the scan lines and owns the digits.
  modport slave (
    input  anode_in, seg_in,
    output min_1, min_0, sec_1, sec_0, frame_valid, digit_err
  );
endinterface

// File: rtl/seven_seg_capture.sv
// Recovers the four stopwatch BCD digits from the multiplexed, active-low
// 7-segment scan. A digit is captured once per scan slot, after the slot's
// {anode, segment} value has been stable for STABLE_CYCLES samples.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input logic              clock,
  input logic              reset,
  seven_seg_capture_if.slave bus
);

  localparam logic [8:0]  CAP_COUNT = 9'(STABLE_CYCLES);
  localparam logic [8:0]  SAT_COUNT = 9'(STABLE_CYCLES + 1);
  localparam logic [10:0] BLANK     = {4'b1111, 7'b1111111};

  // True when exactly one anode line is driven low.
  function automatic logic is_one_cold(input logic [3:0] an);
    case (an)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: is_one_cold = 1'b1;
      default:                           is_one_cold = 1'b0;
    endcase
  endfunction

  // Mask bit for the slot: bit3=min_1, bit2=min_0, bit1=sec_1, bit0=sec_0.
  function automatic logic [3:0] slot_of(input logic [3:0] an);
    case (an)
      4'b0111: slot_of = 4'b1000;
      4'b1011: slot_of = 4'b0100;
      4'b1101: slot_of = 4'b0010;
      4'b1110: slot_of = 4'b0001;
      default: slot_of = 4'b0000;
    endcase
  endfunction

  // Active-low a..g pattern to {valid, digit}.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: seg_decode = {1'b1, 4'd0};
      7'b1001111: seg_decode = {1'b1, 4'd1};
      7'b0010010: seg_decode = {1'b1, 4'd2};
      7'b0000110: seg_decode = {1'b1, 4'd3};
      7'b1001100: seg_decode = {1'b1, 4'd4};
      7'b0100100: seg_decode = {1'b1, 4'd5};
      7'b0100000: seg_decode = {1'b1, 4'd6};
      7'b0001111: seg_decode = {1'b1, 4'd7};
      7'b0000000: seg_decode = {1'b1, 4'd8};
      7'b0000100: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  logic [10:0] s1_r, s2_r;
  logic [8:0]  cnt_r, cnt_next_s;
  logic [3:0]  mask_r, mask_next_s, mask_upd_s, slot_s;
  logic [15:0] digits_r, digits_next_s;
  logic        fv_r, fv_next_s, err_r, err_next_s;
  logic        capture_s;
  logic [4:0]  dec_s;

  // Two-stage sample pipeline of the scan lines plus the dwell counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_r  <= BLANK;
      s2_r  <= BLANK;
      cnt_r <= 9'd0;
    end else begin
      s1_r  <= {bus.anode_in, bus.seg_in};
      s2_r  <= s1_r;
      cnt_r <= cnt_next_s;
    end
  end

  // Dwell length: restart on any change, otherwise count up to one past the
  // capture point so a long dwell captures only once.
  always_comb begin
    cnt_next_s = cnt_r;
    if (s1_r != s2_r) begin
      cnt_next_s = 9'd1;
    end else if (cnt_r < SAT_COUNT) begin
      cnt_next_s = cnt_r + 9'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Capture decision: update one digit and the seen-mask, or flag a bad pattern.
  always_comb begin
    slot_s        = slot_of(s2_r[10:7]);
    dec_s         = seg_decode(s2_r[6:0]);
    capture_s     = (cnt_r == CAP_COUNT) && is_one_cold(s2_r[10:7]);
    mask_upd_s    = mask_r | slot_s;
    mask_next_s   = mask_r;
    digits_next_s = digits_r;
    fv_next_s     = 1'b0;
    err_next_s    = 1'b0;
    if (capture_s) begin
      if (dec_s[4]) begin
        case (slot_s)
          4'b1000: digits_next_s[15:12] = dec_s[3:0];
          4'b0100: digits_next_s[11:8]  = dec_s[3:0];
          4'b0010: digits_next_s[7:4]   = dec_s[3:0];
          4'b0001: digits_next_s[3:0]   = dec_s[3:0];
          default: digits_next_s        = digits_r;
        endcase
        if (mask_upd_s == 4'b1111) begin
          mask_next_s = 4'b0000;
          fv_next_s   = 1'b1;
        end else begin
          mask_next_s = mask_upd_s;
          fv_next_s   = 1'b0;
        end
      end else begin
        err_next_s = 1'b1;
      end
    end else begin
      mask_next_s = mask_r;
    end
  end

  // Registered digit, mask and pulse state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mask_r   <= 4'b0000;
      digits_r <= 16'h0000;
      fv_r     <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      mask_r   <= mask_next_s;
      digits_r <= digits_next_s;
      fv_r     <= fv_next_s;
      err_r    <= err_next_s;
    end
  end

  assign bus.min_1       = digits_r[15:12];
  assign bus.min_0       = digits_r[11:8];
  assign bus.sec_1       = digits_r[7:4];
  assign bus.sec_0       = digits_r[3:0];
  assign bus.frame_valid = fv_r;
  assign bus.digit_err   = err_r;

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Decodes the multiplexed 7-segment scan (anode select plus active-low cathode pattern) back into the four stopwatch BCD digits.
- Sits on the loopback/monitor path beside the display driver. It lets the stopwatch self-check, and the bench compares displayed time against counter time.
- Captures each digit only after its scan slot has been stable for a programmable dwell.
- Reports completed frames and undecodable patterns.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples of {anode_in, seg_in} needed before a capture; legal range 1..255.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; asserted when 0
anode_in  input  4  active-low anode select, one-cold when valid
seg_in  input  7  active-low cathodes, bit6=a ... bit0=g
min_1  output  4  captured tens-of-minutes digit (anode 0111)
min_0  output  4  captured minutes digit (anode 1011)
sec_1  output  4  captured tens-of-seconds digit (anode 1101)
sec_0  output  4  captured seconds digit (anode 1110)
frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last pulse or reset
digit_err  output  1  one-cycle pulse when a stable, validly-anoded pattern does not decode

Behaviour:
- Reset (reset=0, async):
  - min_1, min_0, sec_1, sec_0 = 0; frame_valid = 0; digit_err = 0.
  - Seen-mask = 0000; dwell counter = 0.
  - Sample registers = anode 1111, seg 1111111 (blank).
  - Reset mid-dwell or mid-frame discards all progress.
- Input sampling:
  - Inputs are synchronous to clock; the block has no synchronizer.
  - Stage s1 registers {anode_in, seg_in} every edge; stage s2 registers s1.
- Dwell counter:
  - s1==s2 -> counter increments, saturating at STABLE_CYCLES+1.
  - s1!=s2 -> counter loads 1.
- Capture condition: counter == STABLE_CYCLES and s2 anode is one-cold. This gives exactly one capture per dwell, however long the dwell lasts.
- Latency:
  - Let E0 be the first edge that samples a new value, held through edge E0+STABLE_CYCLES-1.
  - The capture effect (digit update, pulses) is registered at edge E0+STABLE_CYCLES+1.
  - Any change before edge E0+STABLE_CYCLES-1 restarts the dwell; no capture occurs.
- Anode handling:
  - Not one-cold (1111, 0000, multiple lows) -> no capture, no error, mask unchanged.
  - 0111 -> min_1; 1011 -> min_0; 1101 -> sec_1; 1110 -> sec_0.
- Decode (seg_in -> digit):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
  - 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
- Valid decode: the selected digit output loads the value and the corresponding mask bit sets. Recapturing an already-seen position overwrites the digit; the mask stays set.
- Invalid decode (any other pattern): digit_err pulses for one cycle on the capture edge. The digit output and mask are unchanged.
- Frame completion:
  - When a valid capture makes the mask 1111, frame_valid pulses in the same cycle the fourth digit updates, and the mask clears to 0000 on that edge.
  - Digits hold their values between captures.
- frame_valid and digit_err are never asserted simultaneously, since a capture is either valid or invalid.

Test Plan:
(All with STABLE_CYCLES=4.)
- Reset: hold reset=0 and toggle inputs -> all digits 0, frame_valid=0, digit_err=0. Release reset with inputs blank for 10 cycles -> no pulses.
- Full frame: drive each slot for 6 cycles:
  - Stimulus: 0111/1001111, then 1011/0010010, then 1101/0100100, then 1110/0000100.
  - Response: min_1=1, min_0=2, sec_1=5, sec_0=9.
  - Each digit updates 5 edges after its first sample.
  - frame_valid pulses exactly once, coincident with the sec_0 update.
- Glitch rejection: 1101/0000110 held 3 cycles, then 1110/0000110 -> sec_1 never changes. Also, a pattern held for exactly 4 sampled cycles (the minimum dwell) is captured.
- Bad pattern: 1101/1111111 held 20 cycles -> digit_err pulses once, sec_1 unchanged, mask unchanged. A subsequent valid 4-slot frame produces frame_valid only after all four valid captures.
- Invalid anode: 0011/0000000 held 12 cycles, then 1111/0000000 held 12 cycles -> no digit change, no frame_valid, no digit_err.
- Reset mid-frame: capture min_1, min_0, sec_1 (values 3, 4, 5); pulse reset=0 for 2 cycles; then capture only sec_0=7.
  - Response: digits read 0, 0, 0, 7 and there is no frame_valid.
  - Capturing the remaining three digits then yields one frame_valid.
